// File: rtl/lpm_pkg.sv
// Shared types for the LPM request concentrator.
// Request kind and queued-request layout.
package lpm_pkg;

    localparam int LPM_ADDR_W = 32;
    localparam int LPM_DATA_W = 32;

    typedef enum logic {
        ENTER = 1'b0,
        WRITE = 1'b1
    } lpm_kind_t;

    typedef struct packed {
        lpm_kind_t             kind;
        logic [LPM_ADDR_W-1:0] addr;
        logic [LPM_DATA_W-1:0] data;
    } lpm_entry_t;

endpackage

// File: rtl/lpm_req_fifo.sv
// Per-channel request FIFO with a registered ready flag.
// Ready is low in reset and while the FIFO holds DEPTH entries.
module lpm_req_fifo
    import lpm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = $bits(lpm_entry_t)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         ready,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          do_push;
    logic          do_pop;

    assign do_push    = push && ready;
    assign do_pop     = pop && !empty;
    assign count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign empty      = (count == '0);
    assign dout       = mem[rd_ptr];

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            ready <= (count_next != (AW+1)'(DEPTH));
        end
    end

endmodule

// File: rtl/lpm_request_mux.sv
// N-channel LPM request concentrator: per-channel FIFOs drained
// round-robin into one registered, channel-tagged downstream port.
module lpm_request_mux
    import lpm_pkg::*;
#(
    parameter int NCHAN      = 4,
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    localparam int CHAN_W    = $clog2(NCHAN)
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic [NCHAN-1:0]            in_enter__ENA,
    input  logic [NCHAN*DATA_WIDTH-1:0] in_enter__data,
    output logic [NCHAN-1:0]            in_enter__RDY,
    input  logic [NCHAN-1:0]            in_write__ENA,
    input  logic [NCHAN*ADDR_WIDTH-1:0] in_write__addr,
    input  logic [NCHAN*DATA_WIDTH-1:0] in_write__data,
    output logic [NCHAN-1:0]            in_write__RDY,
    output logic                        out_enter__ENA,
    output logic [DATA_WIDTH-1:0]       out_enter__data,
    output logic [CHAN_W-1:0]           out_enter__chan,
    input  logic                        out_enter__RDY,
    output logic                        out_write__ENA,
    output logic [ADDR_WIDTH-1:0]       out_write__addr,
    output logic [DATA_WIDTH-1:0]       out_write__data,
    output logic [CHAN_W-1:0]           out_write__chan,
    input  logic                        out_write__RDY,
    output logic [NCHAN-1:0]            err
);

    localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;

    logic [NCHAN-1:0]      rdy;
    logic [NCHAN-1:0]      empty;
    logic [NCHAN-1:0]      push;
    logic [NCHAN-1:0]      pop;
    logic [NCHAN-1:0]      viol;
    logic [EW-1:0]         din  [NCHAN];
    logic [EW-1:0]         dout [NCHAN];
    logic [EW-1:0]         sel;

    logic                  out_valid;
    lpm_kind_t             out_kind;
    logic [CHAN_W-1:0]     out_chan;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;

    logic [CHAN_W-1:0]     rr_ptr;
    logic [CHAN_W-1:0]     grant;
    logic                  grant_found;
    logic [CHAN_W:0]       sum;
    logic                  fire;
    logic                  load;

    assign in_enter__RDY = rdy;
    assign in_write__RDY = rdy;

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        logic ena_e;
        logic ena_w;

        assign ena_e = in_enter__ENA[i];
        assign ena_w = in_write__ENA[i];

        // A write wins over a same-cycle enter on one channel.
        assign push[i] = (ena_e || ena_w) && rdy[i];
        assign viol[i] = ((ena_e || ena_w) && !rdy[i]) || (ena_e && ena_w);
        assign pop[i]  = load && (grant == CHAN_W'(i));
        assign din[i]  = ena_w
            ? {1'(WRITE),
               in_write__addr[i*ADDR_WIDTH +: ADDR_WIDTH],
               in_write__data[i*DATA_WIDTH +: DATA_WIDTH]}
            : {1'(ENTER),
               {ADDR_WIDTH{1'b0}},
               in_enter__data[i*DATA_WIDTH +: DATA_WIDTH]};

        lpm_req_fifo #(
            .DEPTH (DEPTH),
            .W     (EW)
        ) u_fifo (
            .clk   (CLK),
            .rst_n (nRST),
            .push  (push[i]),
            .din   (din[i]),
            .pop   (pop[i]),
            .dout  (dout[i]),
            .ready (rdy[i]),
            .empty (empty[i])
        );
    end

    // Round-robin search for the first non-empty FIFO from rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        sum         = '0;
        for (int k = 0; k < NCHAN; k++) begin
            sum = {1'b0, rr_ptr} + (CHAN_W+1)'(k);
            if (sum >= (CHAN_W+1)'(NCHAN)) begin
                sum = sum - (CHAN_W+1)'(NCHAN);
            end
            if (!grant_found && !empty[sum[CHAN_W-1:0]]) begin
                grant_found = 1'b1;
                grant       = sum[CHAN_W-1:0];
            end
        end
    end

    assign sel  = dout[grant];
    assign fire = out_valid &&
                  ((out_kind == WRITE) ? out_write__RDY : out_enter__RDY);
    assign load = (!out_valid || fire) && grant_found;

    // Output stage register and round-robin pointer.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_valid <= 1'b0;
            out_kind  <= ENTER;
            out_chan  <= '0;
            out_addr  <= '0;
            out_data  <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_kind  <= lpm_kind_t'(sel[EW-1]);
            out_chan  <= grant;
            out_addr  <= sel[DATA_WIDTH +: ADDR_WIDTH];
            out_data  <= sel[DATA_WIDTH-1:0];
            rr_ptr    <= (grant == CHAN_W'(NCHAN-1)) ? '0 : grant + 1'b1;
        end else if (fire) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky per-channel protocol violation flags.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err <= '0;
        end else begin
            err <= err | viol;
        end
    end

    assign out_enter__ENA  = out_valid && (out_kind == ENTER) && out_enter__RDY;
    assign out_write__ENA  = out_valid && (out_kind == WRITE) && out_write__RDY;
    assign out_enter__data = out_data;
    assign out_enter__chan = out_chan;
    assign out_write__addr = out_addr;
    assign out_write__data = out_data;
    assign out_write__chan = out_chan;

endmodule

// File: tb/tb_lpm_request_mux.sv
// Randomized and directed bench for lpm_request_mux.
// Queue-based reference model compared every cycle.
module tb_lpm_request_mux;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          nRST;
    logic [N-1:0]  in_enter_ena;
    logic [N*DW-1:0] in_enter_data;
    logic [N-1:0]  in_enter_rdy;
    logic [N-1:0]  in_write_ena;
    logic [N*AW-1:0] in_write_addr;
    logic [N*DW-1:0] in_write_data;
    logic [N-1:0]  in_write_rdy;
    logic          out_enter_ena;
    logic [DW-1:0] out_enter_data;
    logic [CW-1:0] out_enter_chan;
    logic          out_enter_rdy;
    logic          out_write_ena;
    logic [AW-1:0] out_write_addr;
    logic [DW-1:0] out_write_data;
    logic [CW-1:0] out_write_chan;
    logic          out_write_rdy;
    logic [N-1:0]  err;

    always #5 clk = ~clk;

    lpm_request_mux #(
        .NCHAN      (N),
        .DEPTH      (D),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .CLK             (clk),
        .nRST            (nRST),
        .in_enter__ENA   (in_enter_ena),
        .in_enter__data  (in_enter_data),
        .in_enter__RDY   (in_enter_rdy),
        .in_write__ENA   (in_write_ena),
        .in_write__addr  (in_write_addr),
        .in_write__data  (in_write_data),
        .in_write__RDY   (in_write_rdy),
        .out_enter__ENA  (out_enter_ena),
        .out_enter__data (out_enter_data),
        .out_enter__chan (out_enter_chan),
        .out_enter__RDY  (out_enter_rdy),
        .out_write__ENA  (out_write_ena),
        .out_write__addr (out_write_addr),
        .out_write__data (out_write_data),
        .out_write__chan (out_write_chan),
        .out_write__RDY  (out_write_rdy),
        .err             (err)
    );

    typedef struct {
        bit          kind;
        int          chan;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    req_t   q [N][$];
    req_t   slot;
    bit     slot_v;
    int     rr;
    bit [N-1:0] merr;
    bit     rdy_ok;
    req_t   flog [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        slot_v = 0;
        rr     = 0;
        merr   = '0;
        rdy_ok = 0;
    endtask

    function automatic bit [N-1:0] exp_rdy();
        bit [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = rdy_ok && (q[i].size() < D);
        return r;
    endfunction

    task automatic check_outputs();
        bit e_en;
        bit e_wr;
        e_en = slot_v && !slot.kind && out_enter_rdy;
        e_wr = slot_v && slot.kind && out_write_rdy;
        chk("in_enter_rdy", in_enter_rdy, exp_rdy());
        chk("in_write_rdy", in_write_rdy, exp_rdy());
        chk("out_enter_ena", out_enter_ena, e_en);
        chk("out_write_ena", out_write_ena, e_wr);
        chk("err", err, merr);
        if (slot_v) begin
            chk("out_enter_data", out_enter_data, slot.data);
            chk("out_enter_chan", out_enter_chan, slot.chan);
            chk("out_write_data", out_write_data, slot.data);
            chk("out_write_addr", out_write_addr, slot.addr);
            chk("out_write_chan", out_write_chan, slot.chan);
        end
    endtask

    task automatic model_step();
        bit [N-1:0] r;
        bit fire;
        bit e;
        bit w;
        req_t t;
        if (!nRST) begin
            model_reset();
            return;
        end
        r = exp_rdy();
        fire = slot_v && (slot.kind ? out_write_rdy : out_enter_rdy);
        if (!slot_v || fire) begin
            bit found;
            found = 0;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (rr + k) % N;
                if (!found && q[idx].size() > 0) begin
                    found  = 1;
                    slot   = q[idx].pop_front();
                    slot_v = 1;
                    rr     = (idx + 1) % N;
                end
            end
            if (!found) slot_v = 0;
        end
        for (int i = 0; i < N; i++) begin
            e = in_enter_ena[i];
            w = in_write_ena[i];
            if (e || w) begin
                if (!r[i]) begin
                    merr[i] = 1;
                end else begin
                    t.kind = w;
                    t.chan = i;
                    t.addr = w ? in_write_addr[i*AW +: AW] : 32'h0;
                    t.data = w ? in_write_data[i*DW +: DW]
                               : in_enter_data[i*DW +: DW];
                    q[i].push_back(t);
                end
                if (e && w) merr[i] = 1;
            end
        end
        rdy_ok = 1;
    endtask

    task automatic cycle();
        req_t f;
        #1;
        check_outputs();
        if (out_enter_ena) begin
            f.kind = 0; f.chan = out_enter_chan;
            f.addr = 0; f.data = out_enter_data;
            flog.push_back(f);
        end
        if (out_write_ena) begin
            f.kind = 1; f.chan = out_write_chan;
            f.addr = out_write_addr; f.data = out_write_data;
            flog.push_back(f);
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        in_enter_ena = '0;
        in_write_ena = '0;
    endtask

    task automatic put_write(input int ch, input logic [31:0] a,
                             input logic [31:0] d);
        in_write_ena[ch] = 1'b1;
        in_write_addr[ch*AW +: AW] = a;
        in_write_data[ch*DW +: DW] = d;
    endtask

    task automatic put_enter(input int ch, input logic [31:0] d);
        in_enter_ena[ch] = 1'b1;
        in_enter_data[ch*DW +: DW] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int fires;
        int bad;
        int prev;
        int guard;
        nRST = 1'b0;
        in_enter_ena = '0; in_write_ena = '0;
        in_enter_data = '0; in_write_data = '0; in_write_addr = '0;
        out_enter_rdy = 1'b1;
        out_write_rdy = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        chk("reset_enter_ena", out_enter_ena, 0);
        chk("reset_write_ena", out_write_ena, 0);
        chk("reset_rdy", in_enter_rdy, 0);
        chk("reset_err", err, 0);
        @(negedge clk);
        cycle();
        nRST = 1'b1;
        cycle();
        chk("rdy_after_reset", in_write_rdy, 4'hF);

        // single enter on ch2: ENA two edges after accept
        put_enter(2, 32'hDEADBEEF);
        cycle();
        idle();
        chk("t1_not_early", out_enter_ena, 0);
        cycle();
        chk("t1_ena", out_enter_ena, 1);
        chk("t1_data", out_enter_data, 32'hDEADBEEF);
        chk("t1_chan", out_enter_chan, 2);
        chk("t1_no_write", out_write_ena, 0);
        cycle();
        chk("t1_one_pulse", out_enter_ena, 0);

        // all channels writing: one fire per cycle, rotating grants
        fires = 0; bad = 0; prev = -1;
        for (int s = 0; s < 8; s++) begin
            idle();
            for (int c = 0; c < N; c++)
                if (in_write_rdy[c]) put_write(c, c, s);
            cycle();
            #1;
            if (out_write_ena) begin
                fires++;
                if (prev >= 0 && int'(out_write_chan) != (prev + 1) % N) bad++;
                prev = out_write_chan;
            end
        end
        idle();
        chk("rr_fires", fires, 7);
        chk("rr_rotation", bad, 0);
        repeat (24) cycle();

        // write stall on ch0: 4 queued + 1 staged then RDY low
        out_write_rdy = 1'b0;
        sent = 0; guard = 0;
        while (sent < 5 && guard < 20) begin
            idle();
            if (in_write_rdy[0]) begin
                put_write(0, 32'h0, 100 + sent);
                sent++;
            end
            cycle();
            guard++;
        end
        idle();
        chk("stall_sent", sent, 5);
        chk("stall_rdy_low", in_write_rdy[0], 0);
        repeat (3) cycle();
        chk("stall_rdy_still_low", in_write_rdy[0], 0);
        chk("stall_err0", err[0], 0);
        flog.delete();
        out_write_rdy = 1'b1;
        guard = 0;
        while (!in_write_rdy[0] && guard < 10) begin
            cycle();
            guard++;
        end
        chk("stall_rdy_back", in_write_rdy[0], 1);
        put_write(0, 32'h0, 105);
        cycle();
        idle();
        repeat (10) cycle();
        chk("stall_count", flog.size(), 6);
        for (int k = 0; k < 6 && k < flog.size(); k++) begin
            chk("stall_order", flog[k].data, 100 + k);
            chk("stall_chan", flog[k].chan, 0);
        end
        chk("stall_err0_end", err[0], 0);

        // mixed stall: enter behind a blocked write
        out_write_rdy = 1'b0;
        put_write(3, 32'h33, 32'h300);
        cycle();
        idle();
        put_enter(3, 32'h301);
        cycle();
        idle();
        flog.delete();
        repeat (5) cycle();
        chk("mixed_no_fire", flog.size(), 0);
        out_write_rdy = 1'b1;
        repeat (4) cycle();
        chk("mixed_count", flog.size(), 2);
        if (flog.size() == 2) begin
            chk("mixed_first_kind", flog[0].kind, 1);
            chk("mixed_first_data", flog[0].data, 32'h300);
            chk("mixed_second_kind", flog[1].kind, 0);
            chk("mixed_second_data", flog[1].data, 32'h301);
        end

        // simultaneous enter + write on ch1
        flog.delete();
        put_write(1, 32'h10, 32'h5);
        put_enter(1, 32'h77);
        cycle();
        idle();
        repeat (4) cycle();
        chk("dual_err1", err[1], 1);
        chk("dual_count", flog.size(), 1);
        if (flog.size() == 1) begin
            chk("dual_kind", flog[0].kind, 1);
            chk("dual_addr", flog[0].addr, 32'h10);
            chk("dual_data", flog[0].data, 32'h5);
        end
        repeat (6) cycle();
        chk("dual_err1_sticky", err[1], 1);

        // randomized traffic
        for (int s = 0; s < 1500; s++) begin
            idle();
            out_enter_rdy = ($urandom_range(0, 3) != 0);
            out_write_rdy = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < N; c++) begin
                int p;
                bit force_it;
                p = $urandom_range(0, 99);
                force_it = ($urandom_range(0, 99) < 2);
                if (in_write_rdy[c] || force_it) begin
                    if (p < 35) put_write(c, $urandom, $urandom);
                    else if (p < 60) put_enter(c, $urandom);
                    else if (p < 61) begin
                        put_write(c, $urandom, $urandom);
                        put_enter(c, $urandom);
                    end
                end
            end
            cycle();
        end
        idle();
        out_enter_rdy = 1'b1;
        out_write_rdy = 1'b1;
        repeat (30) cycle();

        // reset with 3 queued and output staged
        out_write_rdy = 1'b0;
        sent = 0; guard = 0;
        while (sent < 4 && guard < 20) begin
            idle();
            if (in_write_rdy[1]) begin
                put_write(1, 32'h1, 200 + sent);
                sent++;
            end
            cycle();
            guard++;
        end
        idle();
        cycle();
        chk("pre_reset_sent", sent, 4);
        #2;
        out_write_rdy = 1'b1;
        nRST = 1'b0;
        model_reset();
        #1;
        chk("async_write_ena", out_write_ena, 0);
        chk("async_enter_ena", out_enter_ena, 0);
        chk("async_rdy", in_write_rdy, 0);
        chk("async_err", err, 0);
        @(negedge clk);
        cycle();
        nRST = 1'b1;
        cycle();
        flog.delete();
        put_write(3, 32'h3, 32'h903);
        put_write(2, 32'h2, 32'h902);
        cycle();
        idle();
        repeat (4) cycle();
        chk("post_reset_count", flog.size(), 2);
        if (flog.size() == 2) begin
            chk("post_reset_first", flog[0].chan, 2);
            chk("post_reset_second", flog[1].chan, 3);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
